// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver (start, DBIT data bits LSB first, stop)
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [4:0]      s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] shift;
  logic            rx_meta;
  logic            rx_s;
  logic [DBIT:0]   shift_ext;

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  assign shift_ext = {rx_s, shift};

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered dout, done/error pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shift        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          // Falling edge is seen every clk; qualification happens at mid-bit.
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == 5'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                // Line went back high before mid-bit: treat as noise.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == 5'd15) begin
              shift <= shift_ext[DBIT:1];
              s_cnt <= '0;
              if (n_cnt == NW'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_cnt == 5'(SB_TICK - 1)) begin
              // Word is delivered even on a bad stop bit; frame_err flags it.
              dout         <= shift;
              rx_done_tick <= 1'b1;
              frame_err    <= ~rx_s;
              s_cnt        <= '0;
              state        <= IDLE;
              busy         <= 1'b0;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver with 16x oversampling. Consumes the single-cycle `s_tick` strobe from the baud generator; one `s_tick` is 1/16 of a bit period.
- Recovers 8N1-style frames from the asynchronous `rx` line.
- Presents each received word on `dout` with a one-cycle `rx_done_tick`, for the downstream FIFO and stopwatch command decoder.

Parameters:
- DBIT, 8, number of data bits per frame, LSB first.
- SB_TICK, 16, number of `s_tick` periods in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- s_tick  input  1  oversample strobe from the baud generator, high for one clk cycle per tick.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-cycle pulse: a frame completed and `dout` was updated.
- frame_err  output  1  one-cycle pulse coincident with `rx_done_tick` when the stop bit was sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; s_cnt=0; n_cnt=0; shift reg=0.
  - dout=0, rx_done_tick=0, frame_err=0, busy=0.
  - Both synchronizer flops=1 (line idle).
- Input sync: `rx` passes through two flops to give `rx_s`. Only `rx_s` is used internally, so there is 2 clk of latency from a pin edge.
- Counters:
  - s_cnt is 5 bits wide, enough for SB_TICK up to 32.
  - n_cnt is clog2(DBIT) bits wide.
  - Both counters change only as stated below.
- IDLE:
  - When rx_s==0 (sampled every clk, independent of s_tick), go to START and clear s_cnt.
  - s_tick is ignored in IDLE.
- START (counts on s_tick only):
  - On s_tick with s_cnt==7: if rx_s==0, go to DATA and clear s_cnt and n_cnt. If rx_s==1 (glitch), go to IDLE with no output.
  - Other s_tick: s_cnt+1.
- DATA (counts on s_tick only):
  - On s_tick with s_cnt==15: shift reg = {rx_s, shift[DBIT-1:1]} and clear s_cnt. Then, if n_cnt==DBIT-1, go to STOP; otherwise n_cnt+1.
  - Other s_tick: s_cnt+1.
  - Samples therefore land at bit centres.
- STOP:
  - On s_tick with s_cnt==SB_TICK-1, on that same clk edge:
    - dout <= shift reg;
    - rx_done_tick <= 1;
    - frame_err <= ~rx_s;
    - clear s_cnt; go to IDLE.
  - Other s_tick: s_cnt+1.
- Output timing:
  - rx_done_tick and frame_err are registered and high for exactly one clk, the cycle after the final stop tick.
  - Both are 0 in every other cycle.
  - dout holds its value until the next completion.
  - On a framing error, dout is still updated.
- busy is registered: (state != IDLE).
- Line behaviour:
  - A line held low after a framing error is treated as a new start bit on the next clk in IDLE. It is re-qualified at mid-bit like any other start.
  - A break condition (line held low) therefore produces repeated frames of 0x00 with frame_err=1.
- s_tick edge cases:
  - s_tick held high is legal; the FSM then advances every clk.
  - If s_tick never pulses, the FSM stays in its current state indefinitely, with no timeout.
- Mid-frame reset: an asynchronous reset drops to IDLE immediately and the partial frame is discarded. There is no pulse on release.
- No receive buffering: the consumer must take dout within one frame time (≈10·16 s_tick).

Test Plan:
- Reset then idle: rst_n low 5 clk, rx=1, s_tick every 163 clk for 2000 clk. Required: dout=0x00, rx_done_tick, frame_err and busy never asserted.
- Single byte: drive 0xA5 as 8N1 at 16 s_tick/bit (start, 1,0,1,0,0,1,0,1, stop). Required: exactly one rx_done_tick ≈152 s_tick after the start edge; dout=0xA5; frame_err=0; busy falls in the same cycle as rx_done_tick.
- Glitch rejection: pull rx low for 3 s_tick periods, then high. Required: busy high for about 8 ticks, then returns to IDLE; no rx_done_tick; dout unchanged.
- Framing error: send 0x3C with the stop bit driven low. Required: one rx_done_tick with frame_err=1 in the same cycle and dout=0x3C. A following valid frame 0x81 gives dout=0x81, frame_err=0.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap. Required: three rx_done_tick pulses in order with dout 0x00, 0xFF, 0x55, all with frame_err=0.
- Mid-frame reset: assert rst_n low during data bit 4 of 0x7E, release it, then send 0xC3. Required: all outputs 0 during reset; no pulse for the aborted 0x7E; dout=0xC3 with one rx_done_tick.
